// File: rtl/pipe_front_regs.sv
// ============================================================================
// Module      : pipe_front_regs
// Description : PC, IF/ID and ID/EX pipeline registers with stall/flush
//               handling and saturating stall/flush event counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_front_regs #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
   parameter int          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             StallF,
   input  logic             StallD,
   input  logic             FlushD,
   input  logic             FlushE,
   input  logic             PCSrcE,
   input  logic [31:0]      PCTargetE,
   input  logic [31:0]      InstrF,
   input  logic [9:0]       CtrlD,
   input  logic [31:0]      RD1D,
   input  logic [31:0]      RD2D,
   input  logic [31:0]      ImmExtD,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       RdD,
   input  logic             CntClr,
   output logic [31:0]      PCF,
   output logic [31:0]      InstrD,
   output logic [31:0]      PCD,
   output logic [31:0]      PCPlus4D,
   output logic             ValidD,
   output logic [9:0]       CtrlE,
   output logic [31:0]      RD1E,
   output logic [31:0]      RD2E,
   output logic [31:0]      ImmExtE,
   output logic [31:0]      PCE,
   output logic [31:0]      PCPlus4E,
   output logic [4:0]       Rs1E,
   output logic [4:0]       Rs2E,
   output logic [4:0]       RdE,
   output logic             ValidE,
   output logic [CNT_W-1:0] StallCnt,
   output logic [CNT_W-1:0] FlushCnt
);

   localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

   // ------------------------------------------------------------------
   // Fetch stage
   // ------------------------------------------------------------------
   logic [31:0] r_pcf;
   logic [31:0] w_pcf_plus4;

   assign w_pcf_plus4 = r_pcf + 32'd4;

   // A redirect from E must win over a fetch stall, else a taken branch
   // arriving during a load-use stall would be lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pcf <= RESET_PC;
      end else if (PCSrcE) begin
         r_pcf <= PCTargetE;
      end else if (!StallF) begin
         r_pcf <= w_pcf_plus4;
      end
   end

   // ------------------------------------------------------------------
   // IF/ID register
   // ------------------------------------------------------------------
   logic [31:0] r_instr_d;
   logic [31:0] r_pc_d;
   logic [31:0] r_pcplus4_d;
   logic        r_valid_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instr_d   <= NOP_INSTR;
         r_pc_d      <= 32'd0;
         r_pcplus4_d <= 32'd0;
         r_valid_d   <= 1'b0;
      end else if (FlushD) begin
         r_instr_d   <= NOP_INSTR;
         r_pc_d      <= 32'd0;
         r_pcplus4_d <= 32'd0;
         r_valid_d   <= 1'b0;
      end else if (!StallD) begin
         r_instr_d   <= InstrF;
         r_pc_d      <= r_pcf;
         r_pcplus4_d <= w_pcf_plus4;
         r_valid_d   <= 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // ID/EX register: no hold path, bubbles come only from FlushE
   // ------------------------------------------------------------------
   logic [9:0]  r_ctrl_e;
   logic [31:0] r_rd1_e;
   logic [31:0] r_rd2_e;
   logic [31:0] r_immext_e;
   logic [31:0] r_pc_e;
   logic [31:0] r_pcplus4_e;
   logic [4:0]  r_rs1_e;
   logic [4:0]  r_rs2_e;
   logic [4:0]  r_rd_e;
   logic        r_valid_e;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ctrl_e    <= 10'd0;
         r_rd1_e     <= 32'd0;
         r_rd2_e     <= 32'd0;
         r_immext_e  <= 32'd0;
         r_pc_e      <= 32'd0;
         r_pcplus4_e <= 32'd0;
         r_rs1_e     <= 5'd0;
         r_rs2_e     <= 5'd0;
         r_rd_e      <= 5'd0;
         r_valid_e   <= 1'b0;
      end else if (FlushE) begin
         r_ctrl_e    <= 10'd0;
         r_rd1_e     <= 32'd0;
         r_rd2_e     <= 32'd0;
         r_immext_e  <= 32'd0;
         r_pc_e      <= 32'd0;
         r_pcplus4_e <= 32'd0;
         r_rs1_e     <= 5'd0;
         r_rs2_e     <= 5'd0;
         r_rd_e      <= 5'd0;
         r_valid_e   <= 1'b0;
      end else begin
         r_ctrl_e    <= CtrlD;
         r_rd1_e     <= RD1D;
         r_rd2_e     <= RD2D;
         r_immext_e  <= ImmExtD;
         r_pc_e      <= r_pc_d;
         r_pcplus4_e <= r_pcplus4_d;
         r_rs1_e     <= Rs1D;
         r_rs2_e     <= Rs2D;
         r_rd_e      <= RdD;
         r_valid_e   <= r_valid_d;
      end
   end

   // ------------------------------------------------------------------
   // Saturating event counters; clear beats increment
   // ------------------------------------------------------------------
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else if (CntClr) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (StallF && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + c_cnt_one;
         end
         if (FlushE && !(&r_flush_cnt)) begin
            r_flush_cnt <= r_flush_cnt + c_cnt_one;
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs are driven straight from registers
   // ------------------------------------------------------------------
   assign PCF      = r_pcf;
   assign InstrD   = r_instr_d;
   assign PCD      = r_pc_d;
   assign PCPlus4D = r_pcplus4_d;
   assign ValidD   = r_valid_d;
   assign CtrlE    = r_ctrl_e;
   assign RD1E     = r_rd1_e;
   assign RD2E     = r_rd2_e;
   assign ImmExtE  = r_immext_e;
   assign PCE      = r_pc_e;
   assign PCPlus4E = r_pcplus4_e;
   assign Rs1E     = r_rs1_e;
   assign Rs2E     = r_rs2_e;
   assign RdE      = r_rd_e;
   assign ValidE   = r_valid_e;
   assign StallCnt = r_stall_cnt;
   assign FlushCnt = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_front_regs.sv
// ============================================================================
// Module      : tb_pipe_front_regs
// Description : Directed scoreboard bench for pipe_front_regs (CNT_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_front_regs;

   localparam int CW = 4;

   logic          clk;
   logic          rst_n;
   logic          StallF, StallD, FlushD, FlushE, PCSrcE, CntClr;
   logic [31:0]   PCTargetE, InstrF;
   logic [9:0]    CtrlD;
   logic [31:0]   RD1D, RD2D, ImmExtD;
   logic [4:0]    Rs1D, Rs2D, RdD;
   logic [31:0]   PCF, InstrD, PCD, PCPlus4D;
   logic          ValidD;
   logic [9:0]    CtrlE;
   logic [31:0]   RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
   logic [4:0]    Rs1E, Rs2E, RdE;
   logic          ValidE;
   logic [CW-1:0] StallCnt, FlushCnt;

   pipe_front_regs #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (32'h0000_0013),
      .CNT_W     (CW)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .StallF    (StallF),
      .StallD    (StallD),
      .FlushD    (FlushD),
      .FlushE    (FlushE),
      .PCSrcE    (PCSrcE),
      .PCTargetE (PCTargetE),
      .InstrF    (InstrF),
      .CtrlD     (CtrlD),
      .RD1D      (RD1D),
      .RD2D      (RD2D),
      .ImmExtD   (ImmExtD),
      .Rs1D      (Rs1D),
      .Rs2D      (Rs2D),
      .RdD       (RdD),
      .CntClr    (CntClr),
      .PCF       (PCF),
      .InstrD    (InstrD),
      .PCD       (PCD),
      .PCPlus4D  (PCPlus4D),
      .ValidD    (ValidD),
      .CtrlE     (CtrlE),
      .RD1E      (RD1E),
      .RD2E      (RD2E),
      .ImmExtE   (ImmExtE),
      .PCE       (PCE),
      .PCPlus4E  (PCPlus4E),
      .Rs1E      (Rs1E),
      .Rs2E      (Rs2E),
      .RdE       (RdE),
      .ValidE    (ValidE),
      .StallCnt  (StallCnt),
      .FlushCnt  (FlushCnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Observable signal selectors
   localparam int S_PCF = 0,  S_INSTRD = 1, S_PCD = 2,   S_PCP4D = 3,  S_VALIDD = 4;
   localparam int S_CTRLE = 5, S_RD1E = 6,  S_RD2E = 7,  S_IMME = 8,   S_PCE = 9;
   localparam int S_PCP4E = 10, S_RS1E = 11, S_RS2E = 12, S_RDE = 13, S_VALIDE = 14;
   localparam int S_STALLC = 15, S_FLUSHC = 16;

   typedef struct {
      int          tag;   // cycle number after which to check; -1 = immediately
      int          sel;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   event chk_now;

   function automatic string sel_name(input int s);
      case (s)
         S_PCF:    return "PCF";
         S_INSTRD: return "InstrD";
         S_PCD:    return "PCD";
         S_PCP4D:  return "PCPlus4D";
         S_VALIDD: return "ValidD";
         S_CTRLE:  return "CtrlE";
         S_RD1E:   return "RD1E";
         S_RD2E:   return "RD2E";
         S_IMME:   return "ImmExtE";
         S_PCE:    return "PCE";
         S_PCP4E:  return "PCPlus4E";
         S_RS1E:   return "Rs1E";
         S_RS2E:   return "Rs2E";
         S_RDE:    return "RdE";
         S_VALIDE: return "ValidE";
         S_STALLC: return "StallCnt";
         default:  return "FlushCnt";
      endcase
   endfunction

   function automatic logic [31:0] get_act(input int s);
      case (s)
         S_PCF:    return PCF;
         S_INSTRD: return InstrD;
         S_PCD:    return PCD;
         S_PCP4D:  return PCPlus4D;
         S_VALIDD: return 32'(ValidD);
         S_CTRLE:  return 32'(CtrlE);
         S_RD1E:   return RD1E;
         S_RD2E:   return RD2E;
         S_IMME:   return ImmExtE;
         S_PCE:    return PCE;
         S_PCP4E:  return PCPlus4E;
         S_RS1E:   return 32'(Rs1E);
         S_RS2E:   return 32'(Rs2E);
         S_RDE:    return 32'(RdE);
         S_VALIDE: return 32'(ValidE);
         S_STALLC: return 32'(StallCnt);
         default:  return 32'(FlushCnt);
      endcase
   endfunction

   task automatic drain(input int now);
      exp_t        e;
      logic [31:0] act;
      while (sb.size() > 0 && sb[0].tag <= now) begin
         e   = sb.pop_front();
         act = get_act(e.sel);
         checks++;
         if (now >= 0 && e.tag < now) begin
            errors++;
            $display("FAIL %s stale check tagged %0d seen at cycle %0d", sel_name(e.sel), e.tag, now);
         end else if (act !== e.val) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", sel_name(e.sel), now, act, e.val);
         end
      end
   endtask

   // Monitor: compares after each rising edge, and on demand for async reset
   always @(posedge clk) cyc++;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         drain(cyc);
      end
   end

   initial begin
      forever begin
         @(chk_now);
         drain(-1);
      end
   end

   task automatic exp(input int s, input logic [31:0] v);
      exp_t e;
      e.tag = cyc + 1;
      e.sel = s;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic exp_now(input int s, input logic [31:0] v);
      exp_t e;
      e.tag = -1;
      e.sel = s;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic clean();
      StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; FlushE = 1'b0;
      PCSrcE = 1'b0; CntClr = 1'b0; PCTargetE = 32'd0;
   endtask

   task automatic reset_checks();
      exp_now(S_PCF, 32'h0);
      exp_now(S_INSTRD, 32'h13);
      exp_now(S_PCD, 32'h0);
      exp_now(S_PCP4D, 32'h0);
      exp_now(S_VALIDD, 32'h0);
      exp_now(S_CTRLE, 32'h0);
      exp_now(S_RD1E, 32'h0);
      exp_now(S_PCE, 32'h0);
      exp_now(S_RDE, 32'h0);
      exp_now(S_VALIDE, 32'h0);
      exp_now(S_STALLC, 32'h0);
      exp_now(S_FLUSHC, 32'h0);
      #1;
      ->chk_now;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clean();
      InstrF  = 32'h0050_0093;
      CtrlD   = 10'h2A5;
      RD1D    = 32'h1111_0001;
      RD2D    = 32'h2222_0002;
      ImmExtD = 32'h0000_0005;
      Rs1D    = 5'd1;
      Rs2D    = 5'd2;
      RdD     = 5'd3;
      rst_n   = 1'b1;
      #1 rst_n = 1'b0;
      reset_checks();

      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Edge 1: first fetch lands in IF/ID
      exp(S_PCF, 32'h4); exp(S_INSTRD, 32'h0050_0093); exp(S_PCD, 32'h0);
      exp(S_PCP4D, 32'h4); exp(S_VALIDD, 32'h1); exp(S_VALIDE, 32'h0);
      @(negedge clk);
      // Edge 2: first instruction reaches ID/EX
      exp(S_PCF, 32'h8); exp(S_PCD, 32'h4); exp(S_VALIDE, 32'h1); exp(S_PCE, 32'h0);
      exp(S_PCP4E, 32'h4); exp(S_CTRLE, 32'h2A5); exp(S_RD1E, 32'h1111_0001);
      exp(S_RD2E, 32'h2222_0002); exp(S_IMME, 32'h5); exp(S_RS1E, 32'h1);
      exp(S_RS2E, 32'h2); exp(S_RDE, 32'h3);
      @(negedge clk);
      // Edge 3: load-use bubble at PCF=8
      StallF = 1'b1; StallD = 1'b1; FlushE = 1'b1; InstrF = 32'h00a0_0113;
      exp(S_PCF, 32'h8); exp(S_INSTRD, 32'h0050_0093); exp(S_PCD, 32'h4);
      exp(S_VALIDD, 32'h1); exp(S_VALIDE, 32'h0); exp(S_CTRLE, 32'h0);
      exp(S_RD1E, 32'h0); exp(S_PCE, 32'h0); exp(S_RDE, 32'h0);
      exp(S_STALLC, 32'h1); exp(S_FLUSHC, 32'h1);
      @(negedge clk);
      // Edge 4: pipeline resumes
      clean();
      exp(S_PCF, 32'hC); exp(S_INSTRD, 32'h00a0_0113); exp(S_PCD, 32'h8);
      exp(S_PCP4D, 32'hC); exp(S_VALIDE, 32'h1); exp(S_PCE, 32'h4);
      exp(S_STALLC, 32'h1); exp(S_FLUSHC, 32'h1);
      @(negedge clk);
      // Edge 5: taken branch
      PCSrcE = 1'b1; PCTargetE = 32'h40; FlushD = 1'b1; FlushE = 1'b1;
      exp(S_PCF, 32'h40); exp(S_INSTRD, 32'h13); exp(S_PCD, 32'h0);
      exp(S_PCP4D, 32'h0); exp(S_VALIDD, 32'h0); exp(S_VALIDE, 32'h0);
      exp(S_PCE, 32'h0); exp(S_FLUSHC, 32'h2);
      @(negedge clk);
      // Edge 6: fetch from target, bubble moves into E
      clean();
      exp(S_PCF, 32'h44); exp(S_PCD, 32'h40); exp(S_VALIDD, 32'h1);
      exp(S_VALIDE, 32'h0); exp(S_PCE, 32'h0);
      @(negedge clk);
      // Edge 7: redirect beats StallF
      PCSrcE = 1'b1; PCTargetE = 32'h100; StallF = 1'b1;
      exp(S_PCF, 32'h100); exp(S_PCD, 32'h44); exp(S_STALLC, 32'h2);
      @(negedge clk);
      // Edge 8/9: PC wrap
      clean();
      PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
      exp(S_PCF, 32'hFFFF_FFFC);
      @(negedge clk);
      clean();
      exp(S_PCF, 32'h0); exp(S_PCD, 32'hFFFF_FFFC); exp(S_PCP4D, 32'h0);
      @(negedge clk);
      // Edge 10: StallD alone holds IF/ID while PC advances
      StallD = 1'b1; InstrF = 32'hDEAD_BEEF;
      exp(S_PCF, 32'h4); exp(S_INSTRD, 32'h00a0_0113); exp(S_PCD, 32'hFFFF_FFFC);
      exp(S_VALIDD, 32'h1); exp(S_STALLC, 32'h2);
      @(negedge clk);
      // Edges 11..30: StallF held, counter saturates at 4'hF
      clean();
      StallF = 1'b1;
      for (int i = 11; i <= 30; i++) begin
         if (i == 22) exp(S_STALLC, 32'hE);
         if (i == 23) exp(S_STALLC, 32'hF);
         if (i == 30) begin
            exp(S_STALLC, 32'hF);
            exp(S_PCF, 32'h4);
         end
         @(negedge clk);
      end
      // Edge 31: clear wins over increment
      CntClr = 1'b1;
      exp(S_STALLC, 32'h0); exp(S_FLUSHC, 32'h0);
      @(negedge clk);
      CntClr = 1'b0;
      exp(S_STALLC, 32'h1);
      @(negedge clk);
      // Reset in the middle of a stall/flush/redirect
      StallF = 1'b1; FlushD = 1'b1; FlushE = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h200;
      #2 rst_n = 1'b0;
      reset_checks();
      @(negedge clk);
      clean();
      InstrF = 32'h0050_0093;
      rst_n  = 1'b1;
      exp(S_PCF, 32'h4); exp(S_PCD, 32'h0); exp(S_INSTRD, 32'h0050_0093);
      exp(S_VALIDD, 32'h1); exp(S_STALLC, 32'h0); exp(S_FLUSHC, 32'h0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);

      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pipe_front_regs.md
PIPE_FRONT_REGS -- requirements
Module: pipe_front_regs

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the fetch PC loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), SHALL be the instruction word inserted on a D-stage flush.
REQ-003 Parameter CNT_W, default 16, SHALL set the width of both event counters.
REQ-004 Ports SHALL be, in order:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- StallF  in  1  hold PC register.
- StallD  in  1  hold IF/ID register.
- FlushD  in  1  bubble IF/ID register.
- FlushE  in  1  bubble ID/EX register.
- PCSrcE  in  1  redirect fetch to PCTargetE.
- PCTargetE  in  32  branch/jump target from E stage.
- InstrF  in  32  instruction word read at PCF.
- CtrlD  in  10  packed decode controls: [9] RegWrite, [8:7] ResultSrc, [6] MemWrite, [5] Jump, [4] Branch, [3:1] ALUControl, [0] ALUSrc.
- RD1D, RD2D, ImmExtD  in  32 each  register-file operands and extended immediate.
- Rs1D, Rs2D, RdD  in  5 each  register indices.
- CntClr  in  1  synchronous clear of both counters.
- PCF  out  32  current fetch PC.
- InstrD, PCD, PCPlus4D  out  32 each  IF/ID contents.
- ValidD  out  1  IF/ID holds a real instruction.
- CtrlE  out  10; RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  32 each; Rs1E, Rs2E, RdE  out  5 each  ID/EX contents.
- ValidE  out  1  ID/EX holds a real instruction.
- StallCnt, FlushCnt  out  CNT_W  event counters.

Function
REQ-005 PC register: PCSrcE=1 SHALL load PCTargetE regardless of StallF; else StallF=0 SHALL load PCF+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0); else hold.
REQ-006 IF/ID: FlushD=1 SHALL load InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, overriding StallD.
REQ-007 IF/ID: FlushD=0, StallD=0 SHALL load InstrD=InstrF, PCD=PCF, PCPlus4D=PCF+4, ValidD=1; FlushD=0, StallD=1 SHALL hold all IF/ID fields.
REQ-008 ID/EX: FlushE=1 SHALL zero every ID/EX field, including CtrlE and ValidE; otherwise SHALL capture the D-side fields each cycle, with ValidE=ValidD.
REQ-009 ID/EX SHALL have no stall input; a load-use bubble is produced solely by FlushE.
REQ-010 Latency: InstrF sampled at edge n SHALL appear on InstrD after edge n and on the E outputs after edge n+1 when no stall or flush intervenes.
REQ-011 StallCnt SHALL increment by 1 each cycle StallF=1, saturating at all-ones.
REQ-012 FlushCnt SHALL increment by 1 each cycle FlushE=1, saturating at all-ones.
REQ-013 CntClr=1 SHALL zero both counters on that edge and take priority over any increment in the same cycle.
REQ-014 The outputs SHALL be pure register outputs, with no combinational input-to-output path.

Reset
REQ-015 rst_n=0 SHALL immediately, without a clock edge, force: PCF=RESET_PC; InstrD=NOP_INSTR; PCD=PCPlus4D=0; ValidD=0; all ID/EX fields=0; ValidE=0; StallCnt=FlushCnt=0.
REQ-016 Reset asserted mid-stall or mid-flush SHALL discard all in-flight state; the first edge after release SHALL behave as REQ-005..REQ-013 with PCF=RESET_PC.

Verification
REQ-017 Reset, then 3 clean cycles with InstrF=32'h00500093 -> PCF=0,4,8,12; cycle 2 ValidD=1 with PCD=0; cycle 3 ValidE=1 with PCE=0.
REQ-018 Load-use (StallF=StallD=FlushE=1 for one cycle at PCF=8) -> PCF stays 8, InstrD/PCD held, ValidE=0 with CtrlE=0 next cycle, StallCnt=1, FlushCnt=1.
REQ-019 Taken branch (PCSrcE=1, PCTargetE=32'h40, FlushD=FlushE=1) -> PCF=32'h40, InstrD=32'h00000013, ValidD=0, ValidE=0.
REQ-020 PCSrcE=1 with StallF=1 in the same cycle -> PCF=PCTargetE.
REQ-021 PCF=32'hFFFF_FFFC with no stall -> PCF=0 next edge.
REQ-022 CNT_W=4, StallF held high 20 cycles -> StallCnt saturates at 4'hF; CntClr and StallF asserted in the same cycle -> StallCnt=0.
